// File: rtl/opl3_timer_irq.sv
// OPL3 timer pair: two prescaled 8-bit up-counters with overflow flags and IRQ.
// Define OPL3_TIMER_IRQ_OUT_EN to drive irq_n and status[7]; otherwise they are tied off.

module opl3_timer_ch #(
  parameter int P = 1018,
  parameter int W = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       st_i,
  input  logic [7:0] preset_i,
  output logic       ovf_o
);

  localparam logic [W-1:0] PMAX = W'(P - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t       state_q;
  logic [W-1:0] pre_q;
  logic [7:0]   cnt_q;
  logic         tick;

  assign tick  = (state_q == RUN) && st_i && (pre_q == PMAX);
  assign ovf_o = tick && (cnt_q == 8'hFF);

  // Run/idle FSM with prescaler and counter; preset only sampled on start/reload
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pre_q   <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (st_i) begin
            state_q <= RUN;
            pre_q   <= '0;
            cnt_q   <= preset_i;
          end
        end
        RUN: begin
          if (!st_i) begin
            state_q <= IDLE;
          end else begin
            pre_q <= tick ? '0 : pre_q + 1'b1;
            if (tick)
              cnt_q <= ovf_o ? preset_i : cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

module opl3_timer_irq #(
  parameter real CLK_FREQ             = 12.727e6,
  parameter real TIMER1_TICK_INTERVAL = 80e-6,
  parameter real TIMER2_TICK_INTERVAL = 320e-6
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] timer1,
  input  logic [7:0] timer2,
  input  logic       st1,
  input  logic       st2,
  input  logic       mt1,
  input  logic       mt2,
  input  logic       irq_rst,
  output logic       ft1,
  output logic       ft2,
  output logic       irq_n,
  output logic [7:0] status
);

  localparam int P1 = $rtoi(TIMER1_TICK_INTERVAL * CLK_FREQ + 0.5);
  localparam int P2 = $rtoi(TIMER2_TICK_INTERVAL * CLK_FREQ + 0.5);
  localparam int W1 = $clog2(P1);
  localparam int W2 = $clog2(P2);

  logic ovf1, ovf2;
  logic ft1_q, ft1_d;
  logic ft2_q, ft2_d;
  logic irq;

  opl3_timer_ch #(.P(P1), .W(W1)) u_t1 (
    .clk      (clk),
    .reset_n  (reset_n),
    .st_i     (st1),
    .preset_i (timer1),
    .ovf_o    (ovf1)
  );

  opl3_timer_ch #(.P(P2), .W(W2)) u_t2 (
    .clk      (clk),
    .reset_n  (reset_n),
    .st_i     (st2),
    .preset_i (timer2),
    .ovf_o    (ovf2)
  );

  // Flag next state: clear on irq_rst, but an unmasked overflow wins
  always_comb begin
    ft1_d = irq_rst ? 1'b0 : ft1_q;
    ft2_d = irq_rst ? 1'b0 : ft2_q;
    if (ovf1 && !mt1) ft1_d = 1'b1;
    if (ovf2 && !mt2) ft2_d = 1'b1;
  end

  // Flag registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ft1_q <= 1'b0;
      ft2_q <= 1'b0;
    end else begin
      ft1_q <= ft1_d;
      ft2_q <= ft2_d;
    end
  end

`ifdef OPL3_TIMER_IRQ_OUT_EN
  logic irq_q;

  // IRQ lags the flags by one cycle
  always_ff @(posedge clk) begin
    if (!reset_n) irq_q <= 1'b0;
    else          irq_q <= ft1_q | ft2_q;
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  assign ft1    = ft1_q;
  assign ft2    = ft2_q;
  assign irq_n  = ~irq;
  assign status = {irq, ft1_q, ft2_q, 5'b0};

endmodule

// File: tb/tb_opl3_timer_irq.sv
// Scoreboard bench for opl3_timer_irq.
// Expectations are queued with their due edge and checked at the following negedge.

module tb_opl3_timer_irq;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] timer1, timer2;
  logic       st1, st2, mt1, mt2, irq_rst;
  logic       ft1, ft2, irq_n;
  logic [7:0] status;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    string       tag;
    int          due;
    logic [10:0] val;
  } exp_t;

  exp_t sb[$];

  opl3_timer_irq dut (
    .clk     (clk),
    .reset_n (reset_n),
    .timer1  (timer1),
    .timer2  (timer2),
    .st1     (st1),
    .st2     (st2),
    .mt1     (mt1),
    .mt2     (mt2),
    .irq_rst (irq_rst),
    .ft1     (ft1),
    .ft2     (ft2),
    .irq_n   (irq_n),
    .status  (status)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // {irq_n, ft1, ft2, status}
  function automatic logic [10:0] ex(logic f1, logic f2, logic irq);
`ifdef OPL3_TIMER_IRQ_OUT_EN
    return {~irq, f1, f2, irq, f1, f2, 5'b0};
`else
    return {1'b1, f1, f2, irq & 1'b0, f1, f2, 5'b0};
`endif
  endfunction

  task automatic push(string tag, int due, logic [10:0] v);
    exp_t e;
    e.tag = tag;
    e.due = due;
    e.val = v;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    while (sb.size() != 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.due < cyc)
        chk({e.tag, "_late"}, cyc, e.due);
      else
        chk(e.tag, {21'b0, irq_n, ft1, ft2, status}, {21'b0, e.val});
    end
  end

  task automatic drain(int bound);
    int t0;
    t0 = cyc;
    while (sb.size() != 0 && cyc < t0 + bound) @(negedge clk);
    if (sb.size() != 0) begin
      chk("timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic wait_cyc(int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic clr_flags(logic irq_prev);
    int c;
    st1 = 1'b0;
    st2 = 1'b0;
    irq_rst = 1'b1;
    c = cyc;
    push("clr", c + 1, ex(1'b0, 1'b0, irq_prev));
    push("clr_irq", c + 2, ex(1'b0, 1'b0, 1'b0));
    @(negedge clk);
    irq_rst = 1'b0;
    drain(10);
  endtask

  initial begin
    int n, r, d, e;
    reset_n = 1'b0;
    timer1 = 8'hFF; timer2 = 8'hFF;
    st1 = 1'b1; st2 = 1'b1;
    mt1 = 1'b0; mt2 = 1'b0;
    irq_rst = 1'b0;

    repeat (3) @(negedge clk);
    push("rst0", cyc + 1, ex(1'b0, 1'b0, 1'b0));
    push("rst1", cyc + 2, ex(1'b0, 1'b0, 1'b0));
    drain(10);
    st1 = 1'b0; st2 = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);

    // Timer 1, preset 0xFF: one tick to overflow
    timer1 = 8'hFF; st1 = 1'b1; n = cyc + 1;
    push("t1_pre", n + 1017, ex(1'b0, 1'b0, 1'b0));
    push("t1_ovf", n + 1018, ex(1'b1, 1'b0, 1'b0));
    push("t1_irq", n + 1019, ex(1'b1, 1'b0, 1'b1));
    drain(1100);
    clr_flags(1'b1);

    // Timer 2, preset 0xFE: two ticks
    timer2 = 8'hFE; st2 = 1'b1; n = cyc + 1;
    push("t2_pre", n + 8145, ex(1'b0, 1'b0, 1'b0));
    push("t2_ovf", n + 8146, ex(1'b0, 1'b1, 1'b0));
    push("t2_irq", n + 8147, ex(1'b0, 1'b1, 1'b1));
    drain(8200);
    clr_flags(1'b1);

    // Masked overflows leave the flag alone; unmasking catches the next one
    timer1 = 8'hFF; mt1 = 1'b1; st1 = 1'b1; n = cyc + 1;
    push("mask_1", n + 1018, ex(1'b0, 1'b0, 1'b0));
    push("mask_5k", n + 5000, ex(1'b0, 1'b0, 1'b0));
    wait_cyc(n + 5010);
    mt1 = 1'b0;
    push("unm_pre", n + 5089, ex(1'b0, 1'b0, 1'b0));
    push("unm_ovf", n + 5090, ex(1'b1, 1'b0, 1'b0));
    push("unm_irq", n + 5091, ex(1'b1, 1'b0, 1'b1));
    drain(200);
    clr_flags(1'b1);

    // irq_rst on the overflow edge: set wins
    timer1 = 8'hFF; st1 = 1'b1; n = cyc + 1;
    wait_cyc(n + 1017);
    irq_rst = 1'b1;
    push("race_ovf", n + 1018, ex(1'b1, 1'b0, 1'b0));
    push("race_irq", n + 1019, ex(1'b1, 1'b0, 1'b1));
    @(negedge clk);
    irq_rst = 1'b0;
    drain(10);
    clr_flags(1'b1);

    // Stop mid-count, restart reloads; preset change waits for reload
    timer1 = 8'hFF; st1 = 1'b1; n = cyc + 1;
    wait_cyc(n + 499);
    st1 = 1'b0;
    wait_cyc(n + 520);
    st1 = 1'b1; r = cyc + 1;
    push("stop_no", n + 1018, ex(1'b0, 1'b0, 1'b0));
    push("rs_pre", r + 1017, ex(1'b0, 1'b0, 1'b0));
    push("rs_ovf", r + 1018, ex(1'b1, 1'b0, 1'b0));
    push("rs_irq", r + 1019, ex(1'b1, 1'b0, 1'b1));
    wait_cyc(r + 10);
    timer1 = 8'h00;
    drain(1100);

    // Reset mid-count, then start from st1 held high at release
    reset_n = 1'b0; d = cyc;
    push("mid_rst0", d + 1, ex(1'b0, 1'b0, 1'b0));
    push("mid_rst1", d + 2, ex(1'b0, 1'b0, 1'b0));
    @(negedge clk);
    @(negedge clk);
    timer1 = 8'hFF;
    reset_n = 1'b1; e = cyc;
    push("rel_pre", e + 1018, ex(1'b0, 1'b0, 1'b0));
    push("rel_ovf", e + 1019, ex(1'b1, 1'b0, 1'b0));
    drain(1100);
    clr_flags(1'b1);

    // Simultaneous overflow of both timers
    timer2 = 8'hFF; st2 = 1'b1; n = cyc + 1;
    wait_cyc(n + 1018);
    timer1 = 8'hFD; st1 = 1'b1;
    push("both_pre", n + 4072, ex(1'b0, 1'b0, 1'b0));
    push("both_ovf", n + 4073, ex(1'b1, 1'b1, 1'b0));
    push("both_irq", n + 4074, ex(1'b1, 1'b1, 1'b1));
    drain(3200);

    // Masking does not clear a set flag
    mt1 = 1'b1; mt2 = 1'b1;
    push("mask_keep", cyc + 1, ex(1'b1, 1'b1, 1'b1));
    drain(10);
    mt1 = 1'b0; mt2 = 1'b0;
    clr_flags(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
